// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALU control codes, instruction op classes, datapath defaults.
package alu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RW_DEF   = 5;

  localparam logic [1:0] OPC_R  = 2'b00;
  localparam logic [1:0] OPC_I  = 2'b01;
  localparam logic [1:0] OPC_LS = 2'b10;
  localparam logic [1:0] OPC_BR = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1011;
  localparam logic [3:0] ALU_BEQ = 4'b1110;
  localparam logic [3:0] ALU_BNE = 4'b1111;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRA) || (code == ALU_SRL);
  endfunction
endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode from (opclass, funct3, funct7[5]).
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] opclass,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  output logic [3:0] alu_ctrl
);
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (opclass)
      OPC_R, OPC_I: begin
        case (funct3)
          3'b000:        alu_ctrl = (opclass == OPC_R && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:        alu_ctrl = ALU_SLL;
          3'b010, 3'b011: alu_ctrl = ALU_SLT;
          3'b100:        alu_ctrl = ALU_XOR;
          3'b101:        alu_ctrl = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:        alu_ctrl = ALU_OR;
          default:       alu_ctrl = ALU_AND;
        endcase
      end
      OPC_LS: alu_ctrl = ALU_ADD;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl = ALU_BEQ;
          3'b001:  alu_ctrl = ALU_BNE;
          default: alu_ctrl = ALU_SUB;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register slot: decodes ALU control, forwards MEM/WB results onto the held
// operands every cycle, stalls on load-use, and hands operands to the ALU via valid/ready.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_opclass,
  input  logic [2:0]      in_funct3,
  input  logic            in_f7b5,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_is_load,
  input  logic            flush,
  input  logic            mem_wen,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [3:0]      alu_ctrl,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_is_load
);
  typedef struct packed {
    logic [1:0]      opclass;
    logic [3:0]      ctrl;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rd;
    logic            is_load;
  } slot_t;

  slot_t      slot, slot_nxt;
  logic       vld;
  logic [3:0] dec_ctrl;
  logic       hazard;
  logic       accept;

  alu_ctrl_dec u_dec (
    .opclass  (in_opclass),
    .funct3   (in_funct3),
    .f7b5     (in_f7b5),
    .alu_ctrl (dec_ctrl)
  );

  // Stall the consumer of a load still sitting in EX; I-type has no rs2 operand.
  assign hazard = vld && slot.is_load && (slot.rd != '0) &&
                  ((slot.rd == in_rs1) || ((slot.rd == in_rs2) && (in_opclass != OPC_I)));
  assign in_ready = (!vld || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    slot_nxt          = slot;
    slot_nxt.opclass  = in_opclass;
    slot_nxt.ctrl     = dec_ctrl;
    slot_nxt.rs1      = in_rs1;
    slot_nxt.rs2      = in_rs2;
    slot_nxt.rs1_data = in_rs1_data;
    slot_nxt.rs2_data = in_rs2_data;
    slot_nxt.imm      = in_imm;
    slot_nxt.rd       = in_rd;
    slot_nxt.is_load  = in_is_load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      slot <= '0;
    end else if (flush) begin
      vld  <= 1'b0;
    end else if (accept) begin
      vld  <= 1'b1;
      slot <= slot_nxt;
    end else if (out_ready) begin
      vld  <= 1'b0;
    end
  end

  function automatic logic [XLEN-1:0] fwd(
    input logic [RW-1:0]   rs,
    input logic [XLEN-1:0] rdata,
    input logic            m_wen,
    input logic [RW-1:0]   m_rd,
    input logic [XLEN-1:0] m_data,
    input logic            w_wen,
    input logic [RW-1:0]   w_rd,
    input logic [XLEN-1:0] w_data
  );
    if (rs == '0)                   return rdata;
    else if (m_wen && (m_rd == rs)) return m_data;
    else if (w_wen && (w_rd == rs)) return w_data;
    else                            return rdata;
  endfunction

  logic [XLEN-1:0] op1, op2, src2_raw;

  always_comb begin
    op1 = fwd(slot.rs1, slot.rs1_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
    op2 = fwd(slot.rs2, slot.rs2_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
    src2_raw = ((slot.opclass == OPC_I) || (slot.opclass == OPC_LS)) ? slot.imm : op2;
  end

  // Shift amount lives in the low 5 bits regardless of operand source.
  assign alu_src1   = op1;
  assign alu_src2   = is_shift(slot.ctrl) ? {{(XLEN-5){1'b0}}, src2_raw[4:0]} : src2_raw;
  assign alu_ctrl   = slot.ctrl;
  assign ex_rd      = slot.rd;
  assign ex_is_load = slot.is_load;
  assign out_valid  = vld;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// behavioural model of the slot, decode table, forwarding and hazard rules.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_opclass;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_is_load, flush;
  logic        mem_wen, wb_wen;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        out_valid, out_ready;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_is_load;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opclass(in_opclass), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rd(in_rd), .in_is_load(in_is_load),
    .flush(flush),
    .mem_wen(mem_wen), .wb_wen(wb_wen), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_data(mem_data), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_ctrl(input logic [1:0] oc, input logic [2:0] f3, input logic b5);
    logic [3:0] alu_tab [8];
    alu_tab = '{4'h0, 4'h6, 4'h5, 4'h5, 4'h4, 4'hB, 4'h3, 4'h2};
    if (oc == 2'b10) return 4'h0;
    if (oc == 2'b11) return (f3 == 3'd0) ? 4'hE : (f3 == 3'd1) ? 4'hF : 4'h1;
    if (f3 == 3'd0 && oc == 2'b00 && b5) return 4'h1;
    if (f3 == 3'd5 && b5) return 4'h7;
    return alu_tab[f3];
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rdat);
    if (rs != 0 && mem_wen && mem_rd == rs) return mem_data;
    if (rs != 0 && wb_wen && wb_rd == rs) return wb_data;
    return rdat;
  endfunction

  typedef struct {
    logic [1:0]  oc;
    logic [2:0]  f3;
    logic        b5;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        ld;
  } inst_t;

  function automatic logic [31:0] ref_src2(input inst_t m);
    logic [3:0]  c;
    logic [31:0] v;
    c = ref_ctrl(m.oc, m.f3, m.b5);
    v = (m.oc == 2'b01 || m.oc == 2'b10) ? m.imm : ref_fwd(m.rs2, m.d2);
    if (c == 4'h6 || c == 4'h7 || c == 4'hB) v = v % 32;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [1:0] oc, input logic [2:0] f3, input logic b5,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] rd, input logic ld);
    in_opclass = oc; in_funct3 = f3; in_f7b5 = b5;
    in_rs1 = rs1; in_rs2 = rs2; in_rs1_data = d1; in_rs2_data = d2;
    in_imm = imm; in_rd = rd; in_is_load = ld;
  endtask

  task automatic idle_fwd;
    mem_wen = 0; wb_wen = 0; mem_rd = 0; wb_rd = 0; mem_data = 0; wb_data = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 0; in_valid = 0; out_ready = 0; flush = 0; idle_fwd();
    set_inst(2'b00, 3'd0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    tick(); tick();
    rst_n = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", alu_ctrl); end
    checks++; if (ex_rd !== 5'd0 || ex_is_load !== 1'b0) begin errors++; $display("FAIL reset_rd: got %0d/%b want 0/0", ex_rd, ex_is_load); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rtype_sub;
    set_inst(2'b00, 3'd0, 1, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 5'd3, 0);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b want 1", out_valid); end
    checks++; if (alu_ctrl !== 4'h1) begin errors++; $display("FAIL sub_ctrl: got %h want 1", alu_ctrl); end
    checks++; if (alu_src1 !== 32'd10 || alu_src2 !== 32'd3) begin errors++; $display("FAIL sub_src: got %0d,%0d want 10,3", alu_src1, alu_src2); end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_srai;
    set_inst(2'b01, 3'd5, 1, 5'd1, 5'd2, 32'h1234, 32'h99, 32'h0000_0405, 5'd4, 0);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    #1;
    checks++; if (alu_ctrl !== 4'h7) begin errors++; $display("FAIL srai_ctrl: got %h want 7", alu_ctrl); end
    checks++; if (alu_src2 !== 32'd5) begin errors++; $display("FAIL srai_src2: got %h want 5", alu_src2); end
    out_ready = 1;
    tick();
  endtask

  task automatic test_forwarding;
    set_inst(2'b00, 3'd0, 0, 5'd5, 5'd6, 32'h11, 32'h22, 32'd0, 5'd1, 0);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    mem_wen = 1; mem_rd = 5; mem_data = 32'hAA; wb_wen = 1; wb_rd = 5; wb_data = 32'hBB;
    #1;
    checks++; if (alu_src1 !== 32'hAA) begin errors++; $display("FAIL fwd_mem: got %h want aa", alu_src1); end
    mem_wen = 0;
    #1;
    checks++; if (alu_src1 !== 32'hBB) begin errors++; $display("FAIL fwd_wb: got %h want bb", alu_src1); end
    checks++; if (alu_src2 !== 32'h22) begin errors++; $display("FAIL fwd_rs2_none: got %h want 22", alu_src2); end
    out_ready = 1; idle_fwd();
    tick();
    set_inst(2'b00, 3'd0, 0, 5'd0, 5'd6, 32'h33, 32'h44, 32'd0, 5'd1, 0);
    in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    mem_wen = 1; mem_rd = 0; mem_data = 32'hAA; wb_wen = 1; wb_rd = 0; wb_data = 32'hBB;
    #1;
    checks++; if (alu_src1 !== 32'h33) begin errors++; $display("FAIL fwd_x0: got %h want 33", alu_src1); end
    out_ready = 1; idle_fwd();
    tick();
  endtask

  task automatic test_load_use;
    set_inst(2'b10, 3'd2, 0, 5'd1, 5'd0, 32'h100, 32'd0, 32'd8, 5'd7, 1);
    in_valid = 1; out_ready = 0;
    tick();
    out_ready = 1;
    set_inst(2'b01, 3'd0, 0, 5'd2, 5'd7, 32'h1, 32'h2, 32'd4, 5'd9, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_itype_rs2: got %b want 1", in_ready); end
    set_inst(2'b00, 3'd0, 0, 5'd2, 5'd7, 32'h1, 32'h2, 32'd0, 5'd9, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || ex_rd !== 5'd9 || ex_is_load !== 1'b0) begin errors++; $display("FAIL lu_accept: got v=%b rd=%0d ld=%b want 1/9/0", out_valid, ex_rd, ex_is_load); end
    tick();
  endtask

  task automatic test_backpressure;
    set_inst(2'b00, 3'd7, 0, 5'd1, 5'd2, 32'h55, 32'h0F, 32'd0, 5'd4, 0);
    in_valid = 1; out_ready = 0;
    tick();
    set_inst(2'b00, 3'd6, 0, 5'd3, 5'd2, 32'h66, 32'hF0, 32'd0, 5'd8, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'h2 || alu_src1 !== 32'h55 || alu_src2 !== 32'h0F || ex_rd !== 5'd4) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b c=%h s1=%h s2=%h rd=%0d want 1/2/55/0f/4", i, out_valid, alu_ctrl, alu_src1, alu_src2, ex_rd); end
      tick();
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || ex_rd !== 5'd8 || alu_ctrl !== 4'h3) begin errors++; $display("FAIL b2b_overwrite: got v=%b rd=%0d c=%h want 1/8/3", out_valid, ex_rd, alu_ctrl); end
    tick();
  endtask

  task automatic test_flush;
    set_inst(2'b11, 3'd1, 0, 5'd1, 5'd2, 32'h5, 32'h6, 32'd0, 5'd0, 0);
    in_valid = 1; out_ready = 0;
    tick();
    checks++; if (alu_ctrl !== 4'hF) begin errors++; $display("FAIL bne_ctrl: got %h want f", alu_ctrl); end
    set_inst(2'b00, 3'd4, 0, 5'd1, 5'd2, 32'h5, 32'h6, 32'd0, 5'd3, 0);
    flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    set_inst(2'b00, 3'd4, 0, 5'd1, 5'd2, 32'h5, 32'h6, 32'd0, 5'd6, 1);
    in_valid = 1; out_ready = 0;
    tick();
    set_inst(2'b00, 3'd1, 0, 5'd1, 5'd2, 32'h5, 32'h6, 32'd0, 5'd9, 0);
    rst_n = 0;
    tick();
    rst_n = 1; in_valid = 0;
    checks++; if (out_valid !== 1'b0 || alu_ctrl !== 4'h0 || ex_rd !== 5'd0 || ex_is_load !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got v=%b c=%h rd=%0d ld=%b want 0/0/0/0", out_valid, alu_ctrl, ex_rd, ex_is_load); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_random;
    inst_t m;
    logic  m_v;
    logic  hz, exp_rdy;
    m_v = 0;
    m = '{oc: 0, f3: 0, b5: 0, rs1: 0, rs2: 0, rd: 0, d1: 0, d2: 0, imm: 0, ld: 0};
    for (int n = 0; n < 400; n++) begin
      set_inst(2'($urandom), 3'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom, $urandom, $urandom, 5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      mem_wen = 1'($urandom); wb_wen = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      mem_data = $urandom; wb_data = $urandom;
      #1;
      hz = m_v && m.ld && m.rd != 0 && (m.rd == in_rs1 || (m.rd == in_rs2 && in_opclass != 2'b01));
      exp_rdy = (!m_v || out_ready) && !hz && !flush;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, in_ready, exp_rdy); end
      checks++; if (out_valid !== m_v) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, m_v); end
      if (m_v) begin
        checks++; if (alu_ctrl !== ref_ctrl(m.oc, m.f3, m.b5)) begin errors++; $display("FAIL rnd_ctrl[%0d]: got %h want %h", n, alu_ctrl, ref_ctrl(m.oc, m.f3, m.b5)); end
        checks++; if (alu_src1 !== ref_fwd(m.rs1, m.d1)) begin errors++; $display("FAIL rnd_src1[%0d]: got %h want %h", n, alu_src1, ref_fwd(m.rs1, m.d1)); end
        checks++; if (alu_src2 !== ref_src2(m)) begin errors++; $display("FAIL rnd_src2[%0d]: got %h want %h", n, alu_src2, ref_src2(m)); end
        checks++; if (ex_rd !== m.rd || ex_is_load !== m.ld) begin errors++; $display("FAIL rnd_rd[%0d]: got %0d/%b want %0d/%b", n, ex_rd, ex_is_load, m.rd, m.ld); end
      end
      if (flush) m_v = 0;
      else if (in_valid && exp_rdy) begin
        m_v = 1;
        m = '{oc: in_opclass, f3: in_funct3, b5: in_f7b5, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
              d1: in_rs1_data, d2: in_rs2_data, imm: in_imm, ld: in_is_load};
      end else if (out_ready) m_v = 0;
      tick();
    end
    in_valid = 0; flush = 0; out_ready = 1; idle_fwd();
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_srai();
    test_forwarding();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Registers one decoded instruction and generates the 4-bit ALU control code from op class, funct3 and funct7[5].
- Applies MEM/WB operand forwarding and detects load-use hazards.
- Presents src1/src2/ALU_control to the ALU under a valid/ready handshake, with flush support for taken branches.

Parameters:
- XLEN, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_opclass  in  2  00 R-type, 01 I-type ALU, 10 load/store, 11 branch.
- in_funct3  in  3  instruction funct3.
- in_f7b5  in  1  funct7[5] (R-type) / imm[10] (I-type shift).
- in_rs1, in_rs2  in  RW  source register indices.
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_rd  in  RW  destination index.
- in_is_load  in  1  instruction is a load.
- flush  in  1  kill the held instruction and the input.
- mem_wen, wb_wen  in  1  MEM/WB stage will write a register.
- mem_rd, wb_rd  in  RW  MEM/WB destination indices.
- mem_data, wb_data  in  XLEN  MEM/WB result data.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream accepts.
- alu_src1, alu_src2  out  XLEN  operands to the ALU.
- alu_ctrl  out  4  ALU control code.
- ex_rd  out  RW  registered destination index.
- ex_is_load  out  1  registered load flag.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0; all held fields=0; therefore alu_ctrl=0000, ex_rd=0, ex_is_load=0.
- Storage: a single register slot.
  - Load when in_valid && in_ready.
  - On load, alu_ctrl is decoded and registered together with the operands.
  - Latency: 1 cycle from acceptance to out_valid.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Hold: when out_valid && !out_ready, all outputs are held stable.
- Drain: when out_valid && out_ready && no load, out_valid falls to 0 next cycle.
- Load-use hazard = out_valid && ex_is_load && ex_rd!=0 && (ex_rd==in_rs1 || (ex_rd==in_rs2 && in_opclass!=01)).
  - While the hazard is active, the input is not accepted.
  - If out_ready is high, a bubble results (out_valid=0 next cycle).
- Flush: out_valid=0 next cycle and the input is not accepted. Flush has priority over the handshake. Reset has priority over flush.
- Forwarding is combinational on the registered rs indices, applied each cycle while the stage is held:
  - MEM has priority over WB, which has priority over register data.
  - A stage matches only when its wen=1, its rd==rs and rs!=0.
- Operand selection:
  - alu_src1 = fwd(rs1).
  - alu_src2 = imm for opclass 01/10; fwd(rs2) for opclass 00/11.
  - For shift codes (0110/0111/1011), alu_src2 = {27'b0, operand[4:0]}.
- alu_ctrl codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 sra, 1011 srl, 1110 beq, 1111 bne.
- Decode for opclass 00/01, by funct3:
  - 000 → add. Exception: sub when opclass 00 && f7b5=1.
  - 001 → 0110.
  - 010 and 011 → 0101.
  - 100 → 0100.
  - 101 → 0111 if f7b5=1, else 1011.
  - 110 → 0011.
  - 111 → 0010.
- Decode for opclass 10: always 0000.
- Decode for opclass 11: funct3 000 → 1110; 001 → 1111; all others → 0001.
- Simultaneous events:
  - Downstream accept plus new input: the slot is overwritten in the same cycle (full throughput).
  - Hazard plus flush: flush wins.
- Reset mid-stall: the slot empties; any pending input is not accepted that cycle.

Decomposition:
- Shared package (alu_pkg):
  - ALU_control code constants.
  - opclass constants.
  - XLEN/RW defaults.
- Sub-module: alu_ctrl_dec. Purely combinational, mapping (opclass, funct3, f7b5) to a 4-bit code, reused by any future decode stage.
- The forwarding mux stays inline.

Test Plan:
- R-type sub: opclass 00, f3=000, f7b5=1, rs1_data=10, rs2_data=3 → next cycle out_valid=1, alu_ctrl=0001, src1=10, src2=3.
- I-type srai: opclass 01, f3=101, f7b5=1, imm=0x0000_0405 → alu_ctrl=0111, src2=5.
- Forwarding:
  - Held rs1=5, mem_wen=1, mem_rd=5, mem_data=0xAA, wb_wen=1, wb_rd=5, wb_data=0xBB → src1=0xAA.
  - Same with mem_wen=0 → src1=0xBB.
  - rs1=0 with any match → register data.
- Load-use: held load with rd=7; input rs2=7, opclass 00 → in_ready=0 for 1 cycle, bubble (out_valid=0), then accepted.
- Backpressure/flush:
  - out_ready=0 for 3 cycles → outputs stable, in_ready=0.
  - flush=1 → out_valid=0 next cycle, input dropped.
- Reset mid-transfer: rst_n=0 at the edge while out_valid=1 → out_valid=0, alu_ctrl=0000, ex_rd=0.
